// File: rtl/parking_lot_ctrl_if.sv
// Gate-sensor and occupancy signal bundle for parking_lot_ctrl.
// The sensor side (master) drives a/b; the controller (slave) drives the rest.
interface parking_lot_ctrl_if #(
  parameter int unsigned CW = 4
);
  logic          a;
  logic          b;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          car_in;
  logic          car_out;
  logic          reject;
  logic          seq_err;

  modport master (
    output a, b,
    input  count, full, empty, car_in, car_out, reject, seq_err
  );

  modport slave (
    input  a, b,
    output count, full, empty, car_in, car_out, reject, seq_err
  );
endinterface

// File: rtl/parking_lot_ctrl.sv
// Parking-lot occupancy controller: decodes entry/exit sequences from the
// outer (a) and inner (b) gate beams and keeps a saturating occupancy count.
module parking_lot_ctrl #(
  parameter int unsigned MAX_COUNT   = 15,
  parameter int unsigned CW          = 4,
  parameter int unsigned SYNC_STAGES = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  parking_lot_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, IN1, IN2, IN3, OUT1, OUT2, OUT3, ERR
  } state_t;

  localparam logic [CW-1:0] MAX_C = CW'(MAX_COUNT);

  state_t        r_state;
  state_t        w_next_state;
  logic [1:0]    w_s;

  logic [CW-1:0] r_count;
  logic          r_full;
  logic          r_empty;
  logic          r_car_in;
  logic          r_car_out;
  logic          r_reject;
  logic          r_seq_err;

  logic          w_entry_done;
  logic          w_exit_done;
  logic [CW-1:0] w_count_nxt;
  logic          w_car_in_nxt;
  logic          w_car_out_nxt;
  logic          w_reject_nxt;
  logic          w_seq_err_nxt;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign w_s = {bus.a, bus.b};
    end else begin : g_sync
      logic [1:0] r_sync [SYNC_STAGES];
      // Sensor synchroniser chain; the FSM sees only the last stage.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int unsigned i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
        end else begin
          r_sync[0] <= {bus.a, bus.b};
          for (int unsigned i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
        end
      end
      assign w_s = r_sync[SYNC_STAGES-1];
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next_state;
  end

  // Next-state decode; holding any sensor value keeps the current state.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE: case (w_s)
              2'b10:   w_next_state = IN1;
              2'b01:   w_next_state = OUT1;
              2'b11:   w_next_state = ERR;
              default: w_next_state = IDLE;
            endcase
      IN1:  case (w_s)
              2'b11:   w_next_state = IN2;
              2'b00:   w_next_state = IDLE;
              2'b01:   w_next_state = ERR;
              default: w_next_state = IN1;
            endcase
      IN2:  case (w_s)
              2'b01:   w_next_state = IN3;
              2'b10:   w_next_state = IN1;
              2'b00:   w_next_state = ERR;
              default: w_next_state = IN2;
            endcase
      IN3:  case (w_s)
              2'b11:   w_next_state = IN2;
              2'b10:   w_next_state = ERR;
              2'b00:   w_next_state = IDLE;
              default: w_next_state = IN3;
            endcase
      OUT1: case (w_s)
              2'b11:   w_next_state = OUT2;
              2'b00:   w_next_state = IDLE;
              2'b10:   w_next_state = ERR;
              default: w_next_state = OUT1;
            endcase
      OUT2: case (w_s)
              2'b10:   w_next_state = OUT3;
              2'b01:   w_next_state = OUT1;
              2'b00:   w_next_state = ERR;
              default: w_next_state = OUT2;
            endcase
      OUT3: case (w_s)
              2'b11:   w_next_state = OUT2;
              2'b01:   w_next_state = ERR;
              2'b00:   w_next_state = IDLE;
              default: w_next_state = OUT3;
            endcase
      ERR:  if (w_s == 2'b00) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Output decode: next count, flags and event pulses from the transition taken.
  always_comb begin
    w_entry_done  = (r_state == IN3)  && (w_s == 2'b00);
    w_exit_done   = (r_state == OUT3) && (w_s == 2'b00);
    w_count_nxt   = r_count;
    w_car_in_nxt  = 1'b0;
    w_car_out_nxt = 1'b0;
    w_reject_nxt  = 1'b0;
    w_seq_err_nxt = (w_next_state == ERR) && (r_state != ERR);
    if (w_entry_done) begin
      if (r_count < MAX_C) begin
        w_count_nxt  = r_count + 1'b1;
        w_car_in_nxt = 1'b1;
      end else begin
        w_reject_nxt = 1'b1;
      end
    end
    if (w_exit_done) begin
      if (r_count != '0) begin
        w_count_nxt   = r_count - 1'b1;
        w_car_out_nxt = 1'b1;
      end else begin
        w_reject_nxt = 1'b1;
      end
    end
  end

  // Count, flags and pulses are registered together so they always agree.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count   <= '0;
      r_full    <= 1'b0;
      r_empty   <= 1'b1;
      r_car_in  <= 1'b0;
      r_car_out <= 1'b0;
      r_reject  <= 1'b0;
      r_seq_err <= 1'b0;
    end else begin
      r_count   <= w_count_nxt;
      r_full    <= (w_count_nxt == MAX_C);
      r_empty   <= (w_count_nxt == '0);
      r_car_in  <= w_car_in_nxt;
      r_car_out <= w_car_out_nxt;
      r_reject  <= w_reject_nxt;
      r_seq_err <= w_seq_err_nxt;
    end
  end

  assign bus.count   = r_count;
  assign bus.full    = r_full;
  assign bus.empty   = r_empty;
  assign bus.car_in  = r_car_in;
  assign bus.car_out = r_car_out;
  assign bus.reject  = r_reject;
  assign bus.seq_err = r_seq_err;

endmodule

// File: tb/tb_parking_lot_ctrl.sv
// Self-checking bench for parking_lot_ctrl (MAX_COUNT=15, CW=4, SYNC_STAGES=0).
module tb_parking_lot_ctrl;

  localparam int MAXC = 15;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  parking_lot_ctrl_if #(.CW(4)) bus ();

  parking_lot_ctrl #(
    .MAX_COUNT  (15),
    .CW         (4),
    .SYNC_STAGES(0)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  typedef struct packed {
    logic [1:0] ab;
    logic [3:0] cnt;
    logic       ci;
    logic       co;
    logic       rj;
    logic       se;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   model_cnt;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every output against an expected count and pulse set.
  task automatic chk_all(input string tag, input int cnt,
                         input logic ci, input logic co, input logic rj, input logic se);
    chk({tag, ".count"},   int'(bus.count),   cnt);
    chk({tag, ".full"},    int'(bus.full),    (cnt == MAXC) ? 1 : 0);
    chk({tag, ".empty"},   int'(bus.empty),   (cnt == 0) ? 1 : 0);
    chk({tag, ".car_in"},  int'(bus.car_in),  int'(ci));
    chk({tag, ".car_out"}, int'(bus.car_out), int'(co));
    chk({tag, ".reject"},  int'(bus.reject),  int'(rj));
    chk({tag, ".seq_err"}, int'(bus.seq_err), int'(se));
  endtask

  // Drive one sensor value for one clock; outputs are checked 1 time unit after the edge.
  task automatic step(input logic [1:0] ab);
    bus.a = ab[1];
    bus.b = ab[0];
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input logic [1:0] ab, input int cnt,
                              input logic ci, input logic co, input logic rj, input logic se);
    tbl.push_back('{ab: ab, cnt: 4'(cnt), ci: ci, co: co, rj: rj, se: se});
  endfunction

  // kind: 1 = entry path, 2 = exit path. Each step held 'hold' cycles; the
  // completion pulse must appear only in the first cycle after the final 00.
  task automatic run_seq(input int kind, input int hold, input string tag);
    logic [1:0] steps [4];
    logic ci, co, rj;
    if (kind == 1) begin
      steps[0] = 2'b10; steps[1] = 2'b11; steps[2] = 2'b01;
    end else begin
      steps[0] = 2'b01; steps[1] = 2'b11; steps[2] = 2'b10;
    end
    steps[3] = 2'b00;
    ci = 1'b0; co = 1'b0; rj = 1'b0;
    for (int s = 0; s < 4; s++) begin
      for (int h = 0; h < hold; h++) begin
        step(steps[s]);
        if (s == 3 && h == 0) begin
          if (kind == 1) begin
            if (model_cnt < MAXC) begin model_cnt++; ci = 1'b1; end
            else rj = 1'b1;
          end else begin
            if (model_cnt > 0) begin model_cnt--; co = 1'b1; end
            else rj = 1'b1;
          end
          chk_all(tag, model_cnt, ci, co, rj, 1'b0);
        end else begin
          chk_all(tag, model_cnt, 1'b0, 1'b0, 1'b0, 1'b0);
        end
      end
    end
  endtask

  initial begin
    bus.a = 1'b0;
    bus.b = 1'b0;
    model_cnt = 0;

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    chk_all("reset", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;

    // Fill to capacity, then one more entry is rejected.
    for (int k = 0; k < MAXC; k++) run_seq(1, 2, "fill");
    chk("fill.full_final", int'(bus.full), 1);
    run_seq(1, 2, "over");
    chk("over.count", int'(bus.count), 15);

    // Drain to empty, then one more exit is rejected.
    for (int k = 0; k < MAXC; k++) run_seq(2, 2, "drain");
    run_seq(2, 2, "under");
    chk("under.empty", int'(bus.empty), 1);

    // Reset, then the table of dwell/exit/error variants (one row per clock).
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    // dwell 00,10,11,11,01,00 -> 1
    add(2'b00,0,0,0,0,0); add(2'b10,0,0,0,0,0); add(2'b11,0,0,0,0,0);
    add(2'b11,0,0,0,0,0); add(2'b01,0,0,0,0,0); add(2'b00,1,1,0,0,0);
    // 00,00,10,11,01,00 -> 2
    add(2'b00,1,0,0,0,0); add(2'b00,1,0,0,0,0); add(2'b10,1,0,0,0,0);
    add(2'b11,1,0,0,0,0); add(2'b01,1,0,0,0,0); add(2'b00,2,1,0,0,0);
    // 00,10,11,01,00 -> 3
    add(2'b00,2,0,0,0,0); add(2'b10,2,0,0,0,0); add(2'b11,2,0,0,0,0);
    add(2'b01,2,0,0,0,0); add(2'b00,3,1,0,0,0);
    // exit 00,01,01,11,10,00 -> 2
    add(2'b00,3,0,0,0,0); add(2'b01,3,0,0,0,0); add(2'b01,3,0,0,0,0);
    add(2'b11,3,0,0,0,0); add(2'b10,3,0,0,0,0); add(2'b00,2,0,1,0,0);
    // exit 00,01,11,10,00 -> 1
    add(2'b00,2,0,0,0,0); add(2'b01,2,0,0,0,0); add(2'b11,2,0,0,0,0);
    add(2'b10,2,0,0,0,0); add(2'b00,1,0,1,0,0);
    // 00,11,00 -> seq_err once, back to IDLE
    add(2'b00,1,0,0,0,0); add(2'b11,1,0,0,0,1); add(2'b00,1,0,0,0,0);
    // 00,10,00 -> backed away, nothing
    add(2'b00,1,0,0,0,0); add(2'b10,1,0,0,0,0); add(2'b00,1,0,0,0,0);
    // 00,10,11,10,11,01,00 -> one car_in
    add(2'b00,1,0,0,0,0); add(2'b10,1,0,0,0,0); add(2'b11,1,0,0,0,0);
    add(2'b10,1,0,0,0,0); add(2'b11,1,0,0,0,0); add(2'b01,1,0,0,0,0);
    add(2'b00,2,1,0,0,0);
    // ERR holds on non-00 without re-pulsing, then a clean entry -> 3
    add(2'b11,2,0,0,0,1); add(2'b10,2,0,0,0,0); add(2'b01,2,0,0,0,0);
    add(2'b00,2,0,0,0,0); add(2'b10,2,0,0,0,0); add(2'b11,2,0,0,0,0);
    add(2'b01,2,0,0,0,0); add(2'b00,3,1,0,0,0);
    // one-cycle-per-step entry from a hold of 00 in IN3 path: 10,11 -> IN2
    add(2'b10,3,0,0,0,0); add(2'b11,3,0,0,0,0);

    foreach (tbl[i]) begin
      step(tbl[i].ab);
      chk_all($sformatf("tbl[%0d]", i), int'(tbl[i].cnt),
              tbl[i].ci, tbl[i].co, tbl[i].rj, tbl[i].se);
    end

    // Now in IN2 with count 3: asynchronous reset aborts immediately.
    reset_n = 1'b0;
    #1;
    chk_all("midreset", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    // From IDLE, 01,00 is an aborted exit attempt: no reject, no count change.
    step(2'b01); chk_all("post_rst0", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(2'b00); chk_all("post_rst1", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    model_cnt = 0;
    run_seq(1, 1, "post_rst_entry");
    chk("post_rst_entry.count", int'(bus.count), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/parking_lot_ctrl.md
# parking_lot_ctrl

Parking-lot occupancy controller: the design under test that consumes the two gate-sensor levels (a = outer beam, b = inner beam) and decodes car entry/exit sequences with a Moore-style FSM. It maintains a saturating occupancy count with full/empty flags and single-cycle event pulses. It sits between the gate sensors (or the stimulus generator in simulation) and the scoreboard/display logic.

## Interface
- MAX_COUNT, 15: lot capacity; count saturates here (1..2^CW-1).
- CW, 4: count width.
- SYNC_STAGES, 0: flops on each sensor input before the FSM (0..3); 0 = sensors are already synchronous to clk.
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
- a  input  1  outer sensor, 1 = beam blocked.
- b  input  1  inner sensor, 1 = beam blocked.
- count  output  CW  current occupancy.
- full  output  1  count == MAX_COUNT.
- empty  output  1  count == 0.
- car_in  output  1  one-cycle pulse on an accepted entry.
- car_out  output  1  one-cycle pulse on an accepted exit.
- reject  output  1  one-cycle pulse: entry completed while full, or exit completed while empty.
- seq_err  output  1  one-cycle pulse on the transition into ERR.

## Operation
- The sampled pair s = {a,b} comes from the last sync stage, or directly from the inputs when SYNC_STAGES = 0.
- States: IDLE, IN1, IN2, IN3, OUT1, OUT2, OUT3, ERR.
- Legal entry path: 00 > 10 > 11 > 01 > 00. Legal exit path: 00 > 01 > 11 > 10 > 00.
- Holding any value keeps the current state, so dwell of any length is legal (e.g. 00,10,11,11,01,00).
- IDLE: 00 stays; 10 -> IN1; 01 -> OUT1; 11 -> ERR.
- IN1: 10 stays; 11 -> IN2; 00 -> IDLE (car backed away, no count change); 01 -> ERR.
- IN2: 11 stays; 01 -> IN3; 10 -> IN1 (backing up); 00 -> ERR.
- IN3: 01 stays; 11 -> IN2; 10 -> ERR; 00 -> IDLE plus entry completion.
- OUT1/OUT2/OUT3 mirror IN1/IN2/IN3 with a and b swapped; 00 from OUT3 -> IDLE plus exit completion.
- ERR: 00 -> IDLE; anything else stays. seq_err pulses only on entry into ERR.
- Entry completion:
  - count < MAX_COUNT: count + 1 and car_in pulses.
  - count == MAX_COUNT: count unchanged and reject pulses.
- Exit completion:
  - count > 0: count - 1 and car_out pulses.
  - count == 0: count unchanged and reject pulses.
- Count never wraps. All arithmetic is CW-bit unsigned.
- full and empty are registered together with count and always agree with it.
- car_in, car_out and reject are mutually exclusive.

## Timing
- Reset values: state IDLE, count 0, empty 1, full 0, all pulses 0, sync flops 0.
- reset_n low mid-sequence aborts it immediately, with no count change beyond clearing to 0. The first sampled edge after deassertion starts from IDLE.
- Latency from a sensor change to the state update is SYNC_STAGES + 1 rising edges.
- On the edge that samples 00 in IN3/OUT3, count, full, empty and the event pulse all update together. All are visible 1 clk (SYNC_STAGES = 0) after the pins return to 00.
- Pulses are high for exactly one cycle.
- No minimum dwell is required: a one-cycle value is a legal step.
- Values shorter than one clock are not guaranteed to be seen.

## Test plan
- Reset then 15 entry sequences (each step held 2 clk) -> count steps 1..15, car_in pulses 15 times, full=1 after the 15th, empty=0.
- At count 15, one more entry sequence -> count stays 15, reject pulses once, car_in stays 0.
- 15 exit sequences then one more -> count steps down to 0, empty=1, the final sequence gives a reject pulse with count still 0.
- After reset, dwell variants -> count 1, 2, 3 respectively:
  - 00,10,11,11,01,00
  - 00,00,10,11,01,00
  - 00,10,11,01,00
- From there, exit variants -> count 2 then 1:
  - 00,01,01,11,10,00
  - 00,01,11,10,00
- Error and abort cases:
  - 00,11,00 -> seq_err pulse, IDLE, count unchanged.
  - 00,10,00 -> no pulses.
  - 00,10,11,10,11,01,00 -> one car_in.
  - reset_n low during IN2 -> count 0, IDLE.
